// File: rtl/mrv32_pkg.sv
// rtl/mrv32_pkg.sv - shared memory sizing and word type for the mrv32 core
package mrv32_pkg;
   localparam int MEM_BYTES  = 65536;
   localparam int ADDR_WIDTH = 32;
   typedef logic [31:0] mem_word_t;
endpackage

// File: rtl/dual_port_byte_ram_rsp_pipe.sv
// rtl/dual_port_byte_ram_rsp_pipe.sv - fixed-latency response shift register for one RAM port
module dual_port_byte_ram_rsp_pipe
   import mrv32_pkg::*;
#(
   parameter int RD_LATENCY = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      in_valid,
   input  mem_word_t in_data,
   output logic      rvalid,
   output mem_word_t rdata
);

   logic [RD_LATENCY-1:0] vld;
   mem_word_t             dat [RD_LATENCY];

   // Data only advances behind a valid bit, so the last stage holds the most
   // recent response; it is also cleared on reset so rdata reads zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld                <= '0;
         dat[RD_LATENCY-1]  <= '0;
      end else begin
         vld[0] <= in_valid;
         if (in_valid) dat[0] <= in_data;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld[i] <= vld[i-1];
            if (vld[i-1]) dat[i] <= dat[i-1];
         end
      end
   end

   assign rvalid = vld[RD_LATENCY-1];
   assign rdata  = dat[RD_LATENCY-1];

endmodule

// File: rtl/dual_port_byte_ram.sv
// rtl/dual_port_byte_ram.sv - dual-port byte RAM; DUAL_PORT_BYTE_RAM_BOUNDS_CHECK_EN enables range checking
module dual_port_byte_ram
   import mrv32_pkg::mem_word_t;
#(
   parameter int MEM_BYTES  = mrv32_pkg::MEM_BYTES,
   parameter int ADDR_WIDTH = mrv32_pkg::ADDR_WIDTH,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_valid,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [31:0]           a_wdata,
   input  logic [3:0]            a_wstrb,
   output logic [31:0]           a_rdata,
   output logic                  a_rvalid,
   input  logic                  b_valid,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [31:0]           b_wdata,
   input  logic [3:0]            b_wstrb,
   output logic [31:0]           b_rdata,
   output logic                  b_rvalid
);

   localparam int WORDS = MEM_BYTES / 4;
   localparam int WIDX  = $clog2(WORDS);

   logic [7:0] mem [0:MEM_BYTES-1];

   logic [WIDX-1:0] a_w, b_w;
   mem_word_t       a_rd, b_rd;
   mem_word_t       a_rsp, b_rsp;
   logic            a_oob, b_oob;
   logic            unused_addr_bits;

   assign a_w = a_addr[WIDX+1:2];
   assign b_w = b_addr[WIDX+1:2];
   assign unused_addr_bits = ^{a_addr, b_addr};

   // Combinational read of the array sampled at the accept edge gives read-before-write.
   assign a_rd = {mem[{a_w, 2'd3}], mem[{a_w, 2'd2}], mem[{a_w, 2'd1}], mem[{a_w, 2'd0}]};
   assign b_rd = {mem[{b_w, 2'd3}], mem[{b_w, 2'd2}], mem[{b_w, 2'd1}], mem[{b_w, 2'd0}]};

`ifdef DUAL_PORT_BYTE_RAM_BOUNDS_CHECK_EN
   assign a_oob = {2'b00, a_addr[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(WORDS);
   assign b_oob = {2'b00, b_addr[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(WORDS);
`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst && a_valid && a_oob) $warning("dual_port_byte_ram: port A address %h out of range", a_addr);
      if (!rst && b_valid && b_oob) $warning("dual_port_byte_ram: port B address %h out of range", b_addr);
   end
`endif
`else
   assign a_oob = 1'b0;
   assign b_oob = 1'b0;
`endif

   assign a_rsp = a_oob ? '0 : a_rd;
   assign b_rsp = b_oob ? '0 : b_rd;

   // Port B is applied last so it wins a same-byte write collision.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            if (a_valid && !a_oob && a_wstrb[i]) mem[{a_w, 2'(i)}] <= a_wdata[8*i +: 8];
         end
         for (int i = 0; i < 4; i++) begin
            if (b_valid && !b_oob && b_wstrb[i]) mem[{b_w, 2'(i)}] <= b_wdata[8*i +: 8];
         end
      end
   end

   dual_port_byte_ram_rsp_pipe #(.RD_LATENCY(RD_LATENCY)) u_a_pipe (
      .clk      (clk),
      .rst      (rst),
      .in_valid (a_valid),
      .in_data  (a_rsp),
      .rvalid   (a_rvalid),
      .rdata    (a_rdata)
   );

   dual_port_byte_ram_rsp_pipe #(.RD_LATENCY(RD_LATENCY)) u_b_pipe (
      .clk      (clk),
      .rst      (rst),
      .in_valid (b_valid),
      .in_data  (b_rsp),
      .rvalid   (b_rvalid),
      .rdata    (b_rdata)
   );

endmodule

// File: tb/tb_dual_port_byte_ram.sv
// tb/tb_dual_port_byte_ram.sv - directed self-checking bench for dual_port_byte_ram
module tb_dual_port_byte_ram;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, b_valid;
   logic [31:0] a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic [3:0]  a_wstrb, b_wstrb;
   logic [31:0] a_rdata, b_rdata;
   logic        a_rvalid, b_rvalid;

   int checks = 0;
   int errors = 0;

   logic [31:0] burst_words [4];
   logic [31:0] exp_far;

   always #5 clk = ~clk;

   dual_port_byte_ram dut (
      .clk      (clk),
      .rst      (rst),
      .a_valid  (a_valid),
      .a_addr   (a_addr),
      .a_wdata  (a_wdata),
      .a_wstrb  (a_wstrb),
      .a_rdata  (a_rdata),
      .a_rvalid (a_rvalid),
      .b_valid  (b_valid),
      .b_addr   (b_addr),
      .b_wdata  (b_wdata),
      .b_wstrb  (b_wstrb),
      .b_rdata  (b_rdata),
      .b_rvalid (b_rvalid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      burst_words[0] = 32'h9300_0013;
      burst_words[1] = 32'h4433_2211;
      burst_words[2] = 32'h8877_6655;
      burst_words[3] = 32'hCCBB_AA99;
`ifdef DUAL_PORT_BYTE_RAM_BOUNDS_CHECK_EN
      exp_far = 32'h0000_0000;
`else
      exp_far = 32'h4433_2211;
`endif
      rst = 1'b1;
      a_valid = 1'b0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
      b_valid = 1'b0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
      tick(); tick();
      check("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
      check("rst_a_rdata", a_rdata, 32'd0);
      check("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
      check("rst_b_rdata", b_rdata, 32'd0);
      rst = 1'b0;

      // Load image words at 0..12 and zero the word at 0x1000 through port B
      b_valid = 1'b1; b_wstrb = 4'hF;
      for (int i = 0; i < 4; i++) begin
         b_addr = 32'(4 * i); b_wdata = burst_words[i];
         tick();
      end
      b_addr = 32'h1000; b_wdata = 32'h0; tick();
      b_valid = 1'b0; b_wstrb = 4'h0;
      tick(); tick();
      check("mem0", {24'd0, dut.mem[0]}, 32'h13);
      check("mem3", {24'd0, dut.mem[3]}, 32'h93);
      check("mem5", {24'd0, dut.mem[5]}, 32'h22);

      // Single read latency and hold
      a_valid = 1'b1; a_addr = 32'h0; a_wstrb = 4'h0; tick();
      a_valid = 1'b0;
      check("a_lat_early", {31'd0, a_rvalid}, 32'd0);
      tick();
      check("a_lat_rvalid", {31'd0, a_rvalid}, 32'd1);
      check("a_lat_rdata", a_rdata, 32'h9300_0013);
      tick();
      check("a_pulse_end", {31'd0, a_rvalid}, 32'd0);
      check("a_rdata_hold", a_rdata, 32'h9300_0013);

      // Partial write then read back on port B
      b_valid = 1'b1; b_addr = 32'h1000; b_wdata = 32'hAABB_CCDD; b_wstrb = 4'b0101; tick();
      b_wstrb = 4'b0000; tick();
      b_valid = 1'b0;
      check("b_wack_rvalid", {31'd0, b_rvalid}, 32'd1);
      check("b_wack_rdata", b_rdata, 32'h0000_0000);
      tick();
      check("b_rd_rvalid", {31'd0, b_rvalid}, 32'd1);
      check("b_rd_rdata", b_rdata, 32'h00BB_00DD);
      tick();

      // Back-to-back reads 0,4,8,12
      for (int i = 0; i < 6; i++) begin
         a_valid = (i < 4); a_addr = 32'(4 * i);
         tick();
         check($sformatf("burst_rvalid%0d", i), {31'd0, a_rvalid}, (i >= 1 && i <= 4) ? 32'd1 : 32'd0);
         if (i >= 1 && i <= 4) check($sformatf("burst_rdata%0d", i), a_rdata, burst_words[i-1]);
      end

      // Write/write collision then read/write collision on 0x20
      a_valid = 1'b1; a_addr = 32'h20; a_wdata = 32'h1111_1111; a_wstrb = 4'hF;
      b_valid = 1'b1; b_addr = 32'h20; b_wdata = 32'h2222_2222; b_wstrb = 4'hF;
      tick();
      a_wstrb = 4'h0; b_wdata = 32'h3333_3333;
      tick();
      a_valid = 1'b0; b_valid = 1'b0; b_wstrb = 4'h0;
      tick();
      check("rd_vs_wr_rvalid", {31'd0, a_rvalid}, 32'd1);
      check("b_wins_old_byte", a_rdata, 32'h2222_2222);
      check("mem20_after", {24'd0, dut.mem[32'h20]}, 32'h33);
      a_valid = 1'b1; a_addr = 32'h20; tick();
      a_valid = 1'b0; tick();
      check("reread_20", a_rdata, 32'h3333_3333);

      // Reset with a read in flight and requests on the reset edge
      a_valid = 1'b1; a_addr = 32'h0; tick();
      a_addr = 32'h4; rst = 1'b1;
      b_valid = 1'b1; b_addr = 32'h1000; b_wdata = 32'hFFFF_FFFF; b_wstrb = 4'hF;
      tick();
      rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; b_wstrb = 4'h0;
      check("rst_fl_a_rvalid0", {31'd0, a_rvalid}, 32'd0);
      check("rst_fl_a_rdata", a_rdata, 32'd0);
      check("rst_fl_b_rvalid", {31'd0, b_rvalid}, 32'd0);
      tick();
      check("rst_fl_a_rvalid1", {31'd0, a_rvalid}, 32'd0);
      tick();
      check("rst_fl_a_rvalid2", {31'd0, a_rvalid}, 32'd0);
      check("rst_mem1000", {24'd0, dut.mem[32'h1000]}, 32'hDD);
      check("rst_mem1003", {24'd0, dut.mem[32'h1003]}, 32'h00);
      check("rst_mem0", {24'd0, dut.mem[0]}, 32'h13);

      // Alignment on A, wrap or bounds on B
      a_valid = 1'b1; a_addr = 32'h7;
      b_valid = 1'b1; b_addr = 32'h0001_0004;
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      check("post_rst_early", {31'd0, a_rvalid}, 32'd0);
      tick();
      check("align_rvalid", {31'd0, a_rvalid}, 32'd1);
      check("align_rdata", a_rdata, 32'h4433_2211);
      check("far_rvalid", {31'd0, b_rvalid}, 32'd1);
      check("far_rdata", b_rdata, exp_far);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
